// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: sweeps all 16 vectors through the basic-gate datapath and
// scores its 7 outputs against a built-in golden model.
module gate_sweep_ctrl #(
    parameter int DWELL = 2,
    parameter int ERR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [3:0]       stim,
    input  logic [6:0]       dut_res,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [3:0]       first_err_vec
);
    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    state_t     state;
    logic [3:0] dwell;
    logic [6:0] golden;
    logic       x;

    // Bit order {xor2, xor1, aoi, nand, not, or, and}; both XOR variants share one reference.
    always_comb begin
        x      = stim[1] ^ stim[0];
        golden = {x, x, ~((stim[3] & stim[2]) | (stim[1] & stim[0])),
                  ~(stim[1] & stim[0]), ~stim[0], stim[1] | stim[0], stim[1] & stim[0]};
    end

    assign pass = done && (err_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            stim            <= '0;
            dwell           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state           <= APPLY;
                    stim            <= '0;
                    dwell           <= '0;
                    busy            <= 1'b1;
                    done            <= 1'b0;
                    err_cnt         <= '0;
                    first_err_valid <= 1'b0;
                    first_err_vec   <= '0;
                end
                APPLY: begin
                    dwell <= dwell + 4'd1;
                    if (dwell == 4'(DWELL - 1)) state <= CHECK;
                end
                CHECK: begin
                    if (dut_res != golden) begin
                        if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_vec   <= stim;
                        end
                    end
                    if (stim == 4'hF) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        stim  <= stim + 4'd1;
                        dwell <= '0;
                        state <= APPLY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
Sequencer that exhaustively exercises the team's 4-input basic-gate datapath (AND, OR, NOT, NAND, AOI, two XOR implementations). After a start pulse it drives all 16 input vectors in order and waits a settle time on each. It then samples the 7 gate outputs and compares them against an internal golden model. It reports the mismatch count, the first failing vector and a pass/done status. It sits between the lab board's start button/LEDs and the gate datapath under test.

Parameters:
DWELL, 2, cycles each vector is held before sampling (legal 1..15)
ERR_W, 5, width of the mismatch counter (must be >= 5 so 16 errors fit)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle or level request to begin a sweep
stim  output  4  input vector driven to the gate datapath (stim[1:0] = 2-input gate operands, stim[3:0] = AOI operands)
dut_res  input  7  gate outputs {xor2, xor1, aoi, nand, not, or, and}, bit0 = and
busy  output  1  high while a sweep is in progress
done  output  1  high from sweep completion until next accepted start or rst
pass  output  1  done && err_cnt == 0
err_cnt  output  ERR_W  number of vectors with any mismatching bit
first_err_valid  output  1  at least one mismatch recorded this sweep
first_err_vec  output  4  stim value of the first mismatching vector

Behaviour:
- Reset (synchronous, rst=1 at rising edge): state IDLE; stim=0, busy=0, done=0, pass=0, err_cnt=0, first_err_valid=0, first_err_vec=0; dwell counter=0. Reset during a sweep aborts it immediately; no partial results are kept.
- States: IDLE, APPLY, CHECK, DONE.
- IDLE/DONE: start=1 at an edge -> APPLY next cycle. On that edge: vec=0, err_cnt=0, first_err_valid=0, first_err_vec=0, done=0, busy=1, dwell counter=0.
- start is ignored while busy (APPLY/CHECK). A level-held start re-triggers only from DONE, after at least one cycle in DONE.
- APPLY: stim=vec held stable. The dwell counter increments each cycle. After DWELL cycles in APPLY -> CHECK.
- CHECK (1 cycle): stim still = vec. Compare dut_res against the golden model:
  and=s1&s0; or=s1|s0; not=~s0; nand=~(s1&s0); aoi=~((s3&s2)|(s1&s0)); xor1=xor2=s1^s0.
  - Any bit differs: err_cnt+1 (saturate at all-ones). If first_err_valid=0, set first_err_valid=1 and first_err_vec=vec.
  - If vec==15 -> DONE, busy=0, done=1.
  - Otherwise vec+1, dwell counter=0 -> APPLY.
- Timing: done rises exactly 16*(DWELL+1) cycles after the start-accept edge; DWELL=2 gives 48.
- DONE: stim holds 15. Results and done stay stable until an accepted start or rst.
- pass is combinational from done and err_cnt; it is 0 whenever done=0.
- dut_res is sampled only in CHECK. Glitches in other cycles have no effect.
- start and rst in the same cycle: rst wins.

Test Plan:
- Golden-correct datapath model, DWELL=2, start pulse -> stim steps 0..15, each vector held 3 cycles; done=1 at cycle 48; pass=1, err_cnt=0, first_err_valid=0.
- dut_res[2] (not) stuck-at-0 -> vectors with s0=0 fail; err_cnt=8, first_err_valid=1, first_err_vec=0, pass=0.
- dut_res[6] inverted only when stim==9 -> err_cnt=1, first_err_vec=9. Multi-bit error on one vector (all 7 bits inverted at stim==4) -> counted once, err_cnt=1.
- start re-asserted at cycles 5 and 20 of a sweep -> ignored; done still at cycle 48, stim sequence unchanged.
- rst=1 at cycle 17 mid-sweep -> next cycle stim=0, busy=0, done=0, err_cnt=0; a new start then gives a full 48-cycle sweep.
- Sweep with errors, then start from DONE with a correct model -> err_cnt and first_err_valid clear on the accept edge; final pass=1.
